stream_drain_fifo: RTL and testbench
====================================

Name: stream_drain_fifo

Overview:
Receiving end of the capture-path valid/data stream produced by the fixed delay line, which has no backpressure. Buffers samples in a DEPTH-entry first-word-fall-through FIFO. Presents them to a downstream consumer (RLE encoder / memory writer) over a valid/ready handshake. Detects and counts samples lost when the consumer stalls too long.

Parameters:
WIDTH, 32, sample width in bits.
DEPTH, 16, FIFO entries; power of two, 4 to 256.
ADDR, 4, log2(DEPTH); must be consistent with DEPTH.

Ports:
clock  input  1  single clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
validIn  input  1  upstream sample strobe; no backpressure possible.
dataIn  input  WIDTH  upstream sample.
readyIn  input  1  downstream consumer can accept the sample this cycle.
validOut  output  1  dataOut holds a valid sample (FIFO not empty).
dataOut  output  WIDTH  head-of-FIFO sample (first-word fall-through).
count  output  ADDR+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
overflow  output  1  sticky: at least one sample dropped since last clear.
clearOverflow  input  1  synchronous clear of overflow and dropCount.
dropCount  output  16  number of dropped samples, saturating at 0xFFFF.

Behaviour:
- Reset (reset=0, asynchronous): rdPtr=wrPtr=0, count=0, validOut=0, full=0, overflow=0, dropCount=0. dataOut is don't-care while validOut=0. Storage array is not reset.
- Reset asserted mid-operation: buffered samples are discarded immediately. The first validIn after release is stored at entry 0.
- pop = validOut & readyIn. push = validIn & (!full | pop).
- Push writes dataIn to mem[wrPtr] and increments wrPtr modulo DEPTH.
- Pop increments rdPtr modulo DEPTH. Pointers wrap naturally at ADDR bits.
- count: +1 on push-only, -1 on pop-only, unchanged on both or neither. full and validOut are derived from count (validOut = count != 0).
- Latency: a sample pushed in cycle N appears on dataOut/validOut in cycle N+1. Memory is written on the edge, read combinationally at rdPtr.
- Empty + validIn + readyIn: sample stored, no pop (validOut was 0). No bypass path.
- Full + validIn + pop in the same cycle: both occur, count stays DEPTH, nothing is dropped.
- Full + validIn + no pop: sample dropped, FIFO unchanged. overflow<=1, dropCount<=dropCount+1 unless already 0xFFFF.
- clearOverflow and a drop in the same cycle: the drop wins. overflow=1, dropCount=1.
- readyIn while empty: no effect. dataOut is held stable while validOut=1 and readyIn=0.
- Non-sample cycles (validIn=0) never alter contents.

Optional Feature:
Macro STREAM_DRAIN_FIFO_AFULL_EN.
- Defined: adds parameter AFULL_LEVEL (default DEPTH-4) and output port almostFull (1 bit).
  - almostFull is registered: it equals (next count >= AFULL_LEVEL) one clock later, i.e. it is aligned with count.
  - Reset value 0.
  - Lets the controller throttle the sampling divider before an overflow occurs.
- Not defined: the port and parameter are absent. All other behaviour is identical.

Test Plan:
1. Reset, then validIn for 3 cycles with data 0xA1, 0xA2, 0xA3, readyIn=1 -> dataOut 0xA1, 0xA2, 0xA3 on successive cycles starting one cycle after the first push; count peaks at 1; overflow=0.
2. readyIn=0, push 16 samples 0..15 -> count=16, full=1. Push 0x99 -> dropped, overflow=1, dropCount=1. Set readyIn=1 -> drains 0..15 in order; 0x99 never appears.
3. Full FIFO, validIn=1 and readyIn=1 for 5 cycles -> count stays 16, dropCount unchanged, output order preserved.
4. Hold full and push 70000 samples with readyIn=0 -> dropCount saturates at 0xFFFF. Pulse clearOverflow -> overflow=0, dropCount=0. Repeat with clearOverflow coincident with a drop -> overflow=1, dropCount=1.
5. Push 8 samples, assert reset=0 asynchronously between edges -> count=0 and validOut=0 immediately. After release, push 0x55 -> dataOut=0x55 next cycle.
6. With STREAM_DRAIN_FIFO_AFULL_EN and AFULL_LEVEL=12 -> almostFull rises in the same cycle count reaches 12, and falls when count drops to 11.

Source files
------------

// File: rtl/stream_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_drain_fifo
// Brief    : FWFT drain FIFO for a no-backpressure sample stream, with drop
//            detection. Optional almostFull via STREAM_DRAIN_FIFO_AFULL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stream_drain_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
`ifdef STREAM_DRAIN_FIFO_AFULL_EN
    ,
    parameter int AFULL_LEVEL = DEPTH - 4
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             validIn,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             readyIn,
    output logic             validOut,
    output logic [WIDTH-1:0] dataOut,
    output logic [ADDR:0]    count,
    output logic             full,
    output logic             overflow,
    input  logic             clearOverflow,
    output logic [15:0]      dropCount
`ifdef STREAM_DRAIN_FIFO_AFULL_EN
    ,
    output logic             almostFull
`endif
);

    localparam logic [ADDR:0] C_DEPTH    = (ADDR+1)'(DEPTH);
    localparam logic [15:0]   C_DROP_MAX = 16'hFFFF;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  wr_ptr_q, rd_ptr_q;
    logic [ADDR:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_count_q, drop_count_d;

    logic w_pop, w_push, w_drop, w_full, w_empty;

    assign w_full  = (count_q == C_DEPTH);
    assign w_empty = (count_q == '0);
    assign w_pop   = !w_empty && readyIn;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = validIn && (!w_full || w_pop);
    assign w_drop  = validIn && !w_push;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A drop coincident with a clear wins: the clear is applied first.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (w_drop) begin
            overflow_d = 1'b1;
            if (clearOverflow) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != C_DROP_MAX) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (clearOverflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) mem[wr_ptr_q] <= dataIn;
    end

`ifdef STREAM_DRAIN_FIFO_AFULL_EN
    localparam logic [ADDR:0] C_AFULL = (ADDR+1)'(AFULL_LEVEL);
    logic almost_full_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) almost_full_q <= 1'b0;
        else        almost_full_q <= (count_d >= C_AFULL);
    end

    assign almostFull = almost_full_q;
`endif

    assign validOut  = !w_empty;
    assign dataOut   = mem[rd_ptr_q];
    assign count     = count_q;
    assign full      = w_full;
    assign overflow  = overflow_q;
    assign dropCount = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_drain_fifo
// Brief    : Directed scoreboard bench for stream_drain_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_drain_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             validIn = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic             readyIn = 1'b0;
    logic             clearOverflow = 1'b0;
    logic             validOut;
    logic [WIDTH-1:0] dataOut;
    logic [ADDR:0]    count;
    logic             full;
    logic             overflow;
    logic [15:0]      dropCount;
`ifdef STREAM_DRAIN_FIFO_AFULL_EN
    logic             almostFull;
`endif

    stream_drain_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .ADDR (ADDR)
`ifdef STREAM_DRAIN_FIFO_AFULL_EN
        ,
        .AFULL_LEVEL(12)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .validIn      (validIn),
        .dataIn       (dataIn),
        .readyIn      (readyIn),
        .validOut     (validOut),
        .dataOut      (dataOut),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .clearOverflow(clearOverflow),
        .dropCount    (dropCount)
`ifdef STREAM_DRAIN_FIFO_AFULL_EN
        ,
        .almostFull   (almostFull)
`endif
    );

    always #5 clock = ~clock;

    int unsigned      checks = 0;
    int unsigned      errors = 0;
    logic [WIDTH-1:0] sb[$];
    int               m_cnt  = 0;
    logic             m_ovf  = 1'b0;
    logic [15:0]      m_drop = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 64'(count), 64'(m_cnt));
        chk("full", 64'(full), 64'(m_cnt == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("dropCount", 64'(dropCount), 64'(m_drop));
`ifdef STREAM_DRAIN_FIFO_AFULL_EN
        chk("almostFull", 64'(almostFull), 64'(m_cnt >= 12));
`endif
    endtask

    // One clock: drive at the falling edge, check head before the rising edge,
    // check registered state at the next falling edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic clr);
        logic pop_m, push_m, drop_m;
        validIn       = v;
        dataIn        = d;
        readyIn       = r;
        clearOverflow = clr;
        #1;
        chk("validOut", 64'(validOut), 64'(m_cnt != 0));
        pop_m = (m_cnt != 0) && r;
        if (pop_m) begin
            chk("dataOut", 64'(dataOut), 64'(sb[0]));
            void'(sb.pop_front());
        end
        push_m = v && ((m_cnt != DEPTH) || pop_m);
        drop_m = v && !push_m;
        if (push_m) sb.push_back(d);
        m_cnt = m_cnt + int'(push_m) - int'(pop_m);
        if (drop_m) begin
            m_ovf = 1'b1;
            if (clr) m_drop = 16'd1;
            else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = '0;
        end
        @(posedge clock);
        @(negedge clock);
        check_state();
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_drop = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        @(negedge clock);
        @(negedge clock);
        check_state();
        chk("rst_validOut", 64'(validOut), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Test 1: pass-through with a ready consumer
        step(1'b1, 32'hA1, 1'b1, 1'b0);
        step(1'b1, 32'hA2, 1'b1, 1'b0);
        step(1'b1, 32'hA3, 1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0);

        // Test 2: fill, one drop, drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h99, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Test 3: full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Test 4: drop counter saturation and clear
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("drop_saturated", 64'(dropCount), 64'hFFFF);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("drop_cleared", 64'(dropCount), 64'h0);
        step(1'b1, 32'hBEEF, 1'b0, 1'b1);
        chk("drop_wins_over_clear", 64'(dropCount), 64'h1);

        // Test 5: asynchronous reset mid-operation
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
        validIn = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_validOut", 64'(validOut), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 32'h55, 1'b0, 1'b0);
        chk("post_reset_head", 64'(dataOut), 64'h55);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Test 6: almostFull threshold crossing (only observable when enabled)
        for (int i = 0; i < 13; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
